load_store_ctrl: RTL and testbench
==================================

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles in ISSUE awaiting mem_ack.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  datapath load/store request, held stable while stall=1.
REQ-006 req_store  in  1  1=store, 0=load.
REQ-007 req_size  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  ADDR_W  byte address from the ALU ADD result.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 stall  out  1  freeze PC/pipeline.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done: access faulted, no register write allowed.
REQ-013 rdata  out  32  extended load result.
REQ-014 mem_req, mem_we  out  1 each  memory request / write enable.
REQ-015 mem_addr  out  ADDR_W-2  word address = req_addr[ADDR_W-1:2].
REQ-016 mem_wdata  out  32; mem_be  out  4  lane-replicated data, byte enables.
REQ-017 mem_ack  in  1; mem_rdata  in  32  memory handshake return.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, DONE.
REQ-019 IDLE: req_valid and legal access -> ISSUE; illegal access -> DONE with err=1, no mem_req; else stay.
REQ-020 ISSUE: mem_req=1; mem_addr, mem_we, mem_be, mem_wdata registered on IDLE exit, stable until ack.
REQ-021 ISSUE: mem_ack=1 -> DONE; load captures extended mem_rdata into rdata on that edge.
REQ-022 ISSUE wait counter SHALL increment each cycle without ack; at TIMEOUT-1 -> DONE with err=1, mem_req dropped.
REQ-023 mem_ack and timeout in same cycle: ack wins, err=0.
REQ-024 DONE: done=1 for exactly one cycle, then unconditionally IDLE; no re-issue of held request.
REQ-025 stall = req_valid and state != DONE (combinational).
REQ-026 Minimum latency: request cycle N, mem_req from N+1, ack at N+1 gives done at N+2.
REQ-027 Byte lanes, off=req_addr[1:0]: B mem_be=0001<<off, byte replicated x4; H mem_be=0011<<(2*off[1]), half replicated x2; W mem_be=1111.
REQ-028 Loads: select lane by off; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-029 rdata SHALL hold its value across stores and errored accesses.
REQ-030 Size codes 011, 110, 111, and BU/HU with req_store=1, SHALL be illegal.
REQ-031 mem_ack outside ISSUE SHALL be ignored.

Reset
REQ-032 rst_n low: state IDLE, counter 0, mem_req=0, mem_we=0, mem_be=0, done=0, err=0, rdata=0, immediately.
REQ-033 Reset during ISSUE SHALL abandon the access; a later mem_ack SHALL be ignored.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: H with off[0]=1 or W with off!=0 illegal (REQ-019 error path).
REQ-035 Macro undefined: misaligned low bits forced (H uses off[1] only, W uses off=0), access proceeds, err never set for alignment.

Structure
REQ-036 Shared package lsu_pkg SHALL hold size-code constants, the FSM state enum, and the TIMEOUT default.
REQ-037 Combinational sub-module lsu_lane_align SHALL perform be/wdata replication and load extraction/extension.

Verification
REQ-038 LB addr 0x103, mem_rdata 0x80FFFFFF, ack next cycle -> mem_be=1000, rdata=0xFFFFFF80, done at N+2.
REQ-039 SH addr 0x202, wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, rdata unchanged.
REQ-040 LW addr 0x001 with macro -> no mem_req, done+err next cycle; without macro -> word 0x000, mem_be=1111.
REQ-041 No ack for 16 cycles -> mem_req low, done=1, err=1; ack on cycle 16 instead -> err=0.
REQ-042 rst_n low during ISSUE, late mem_ack -> state IDLE, no done, outputs at reset values.
REQ-043 Back-to-back LW then SW, req_valid held -> exactly two mem_req transactions, two done pulses.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 size codes,
// FSM state encoding and the default ISSUE timeout.
package lsu_pkg;

  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store controller.
// Store side: byte enables and lane-replicated write data from size/offset.
// Load side: lane extraction and sign/zero extension of the returned word.
// Halfword offsets use only bit 1 and word offsets are treated as 0, so a
// misaligned access that is allowed through (LSU_MISALIGN_TRAP_EN undefined)
// lands on the enclosing aligned lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Byte enables and replicated data for the outgoing request
  always_comb begin
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    case (st_size)
      SZ_B, SZ_BU: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        st_be        = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of the returned memory word
  always_comb begin
    ld_byte = 8'(ld_raw >> {ld_off, 3'b000});
    ld_half = 16'(ld_raw >> {ld_off[1], 4'b0000});
    case (ld_size)
      SZ_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_data = {24'h0, ld_byte};
      SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// Load/store unit controller: turns one datapath request into one memory
// handshake, stalls the pipeline meanwhile and returns the extended load data.
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned H/HU/W accesses fault
// instead of being forced onto aligned lanes.
//
//   state    | meaning
//   ST_IDLE  | waiting for req_valid; illegal requests go straight to ST_DONE
//   ST_ISSUE | mem_req held with registered address/data until ack or timeout
//   ST_DONE  | one-cycle done pulse (err qualifies it), then back to ST_IDLE
module load_store_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ld_size;
  logic [1:0]       ld_off;
  logic             legal;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata_rep;
  logic [31:0]      ld_data;

  lsu_lane_align u_align (
    .st_size      (req_size),
    .st_off       (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (ld_size),
    .ld_off       (ld_off),
    .ld_raw       (mem_rdata),
    .ld_data      (ld_data)
  );

  // Freeze the pipeline for the whole request except its completion cycle
  assign stall = req_valid && (state != ST_DONE);

  // Request legality: reserved size codes and unsigned stores fault
  always_comb begin
    case (req_size)
      SZ_B, SZ_H, SZ_W: legal = 1'b1;
      SZ_BU, SZ_HU:     legal = !req_store;
      default:          legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == SZ_H || req_size == SZ_HU) && req_addr[0])
      legal = 1'b0;
    if (req_size == SZ_W && req_addr[1:0] != 2'b00)
      legal = 1'b0;
`endif
  end

  // Controller FSM with registered memory-side and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      ld_size   <= SZ_W;
      ld_off    <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (legal) begin
              state     <= ST_ISSUE;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= st_be;
              mem_addr  <= req_addr[ADDR_W-1:2];
              mem_wdata <= st_wdata_rep;
              ld_size   <= req_size;
              ld_off    <= req_addr[1:0];
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            done    <= 1'b1;
            err     <= 1'b0;
            if (!mem_we) rdata <= ld_data;
          end else if (cnt == CNT_MAX) begin
            state   <= ST_DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          cnt   <= '0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed bench for load_store_ctrl: a table of single transactions plus
// hand-written reset-abort and back-to-back sequences.
module tb_load_store_ctrl;
  import lsu_pkg::*;

  localparam int TO = 16;
  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_store;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_ctrl #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;     // ISSUE cycle index that gets mem_ack, -1 never
    logic [31:0] rdin;
    int          exp_issue;  // cycles with mem_req high
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t        v;
    int          issue, lat, txns, dones;
    logic        got, prev_req;
    logic [31:0] exp_rd;

    vecs[0]  = '{1'b0, SZ_B,  32'h103, 32'h0,        0, 32'h80FF_FFFF, 1, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{1'b1, SZ_H,  32'h202, 32'h0000_ABCD, 2, JUNK,         3, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[2]  = '{1'b0, SZ_BU, 32'h101, 32'h0,        1, 32'h1234_8056, 2, 1'b0, 4'b0010, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b0, SZ_H,  32'h102, 32'h0,        0, 32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h0,         32'hFFFF_8001};
    vecs[4]  = '{1'b0, SZ_HU, 32'h100, 32'h0,        0, 32'h1234_F00D, 1, 1'b0, 4'b0011, 32'h0,         32'h0000_F00D};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[5]  = '{1'b0, SZ_W,  32'h001, 32'h0,        0, 32'hDEAD_BEEF, 0, 1'b1, 4'b1111, 32'h0,         32'h0};
`else
    vecs[5]  = '{1'b0, SZ_W,  32'h001, 32'h0,        0, 32'hDEAD_BEEF, 1, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
`endif
    vecs[6]  = '{1'b1, SZ_B,  32'h003, 32'h0000_00A5, 0, JUNK,         1, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{1'b0, 3'b011, 32'h040, 32'h0,       0, JUNK,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, SZ_BU, 32'h044, 32'h0000_0011, 0, JUNK,         0, 1'b1, 4'b0000, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, SZ_W,  32'h010, 32'h0,        -1, JUNK,        TO, 1'b1, 4'b1111, 32'h0,         32'h0};
    vecs[10] = '{1'b0, SZ_W,  32'h020, 32'h0,   TO - 1, 32'h0BAD_F00D, TO, 1'b0, 4'b1111, 32'h0,         32'h0BAD_F00D};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[11] = '{1'b0, SZ_HU, 32'h201, 32'h0,        0, 32'hFFFF_1234, 0, 1'b1, 4'b0011, 32'h0,         32'h0};
`else
    vecs[11] = '{1'b0, SZ_HU, 32'h201, 32'h0,        0, 32'hFFFF_1234, 1, 1'b0, 4'b0011, 32'h0,         32'h0000_1234};
`endif
    vecs[12] = '{1'b1, SZ_W,  32'h30C, 32'h1122_3344, 1, JUNK,         2, 1'b0, 4'b1111, 32'h1122_3344, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = SZ_W;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = JUNK;
    repeat (3) @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset done",    32'(done),    32'd0);
    chk("reset err",     32'(err),     32'd0);
    chk("reset rdata",   rdata,        32'h0);
    chk("reset mem_be",  32'(mem_be),  32'h0);
    chk("reset mem_we",  32'(mem_we),  32'd0);
    rst_n = 1'b1;
    exp_rd = 32'h0;

    // Table of single transactions
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      req_valid = 1'b1; req_store = v.store; req_size = v.size;
      req_addr = v.addr; req_wdata = v.wdata;
      #1 chk($sformatf("v%0d stall_req", i), 32'(stall), 32'd1);
      issue = 0; got = 1'b0; lat = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = JUNK;
        if (done) begin got = 1'b1; lat = c; break; end
        if (mem_req) begin
          if (issue == 0) begin
            chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(v.store));
            chk($sformatf("v%0d mem_be", i),    32'(mem_be),    32'(v.exp_be));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,      v.exp_wdata);
            chk($sformatf("v%0d mem_addr", i),  32'(mem_addr),  v.addr >> 2);
          end
          if (issue == v.ack_at) begin mem_ack = 1'b1; mem_rdata = v.rdin; end
          issue++;
        end
      end
      chk($sformatf("v%0d done_seen", i),  32'(got),     32'd1);
      chk($sformatf("v%0d issue_cyc", i),  32'(issue),   32'(v.exp_issue));
      chk($sformatf("v%0d latency", i),    32'(lat),     32'(v.exp_issue + 1));
      chk($sformatf("v%0d err", i),        32'(err),     32'(v.exp_err));
      chk($sformatf("v%0d mem_req_off", i), 32'(mem_req), 32'd0);
      chk($sformatf("v%0d stall_done", i), 32'(stall),   32'd0);
      if (!v.store && !v.exp_err) exp_rd = v.exp_load;
      chk($sformatf("v%0d rdata", i),      rdata,        exp_rd);
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d done_pulse", i), 32'(done),    32'd0);
      chk($sformatf("v%0d no_reissue", i), 32'(mem_req), 32'd0);
    end

    // Back-to-back LW then SW with req_valid held across both
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_W;
    req_addr = 32'h400; req_wdata = 32'h0;
    txns = 0; dones = 0; prev_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = JUNK;
      if (mem_req && !prev_req) begin
        txns++;
        if (txns == 2) chk("b2b second mem_we", 32'(mem_we), 32'd1);
      end
      prev_req = mem_req;
      if (mem_req) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001; end
      if (done) begin
        dones++;
        if (dones == 1) begin
          req_store = 1'b1; req_addr = 32'h404; req_wdata = 32'h7777_8888;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b transactions", 32'(txns),  32'd2);
    chk("b2b done pulses",  32'(dones), 32'd2);
    chk("b2b rdata",        rdata,      32'hCAFE_0001);

    // Reset while in ISSUE, then a late ack after release
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_W; req_addr = 32'h500;
    @(negedge clk);
    chk("rst_abort in issue", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_abort mem_req", 32'(mem_req), 32'd0);
    chk("rst_abort mem_be",  32'(mem_be),  32'h0);
    chk("rst_abort mem_we",  32'(mem_we),  32'd0);
    chk("rst_abort done",    32'(done),    32'd0);
    chk("rst_abort err",     32'(err),     32'd0);
    chk("rst_abort rdata",   rdata,        32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (done || mem_req) got = 1'b1;
    end
    chk("late_ack activity", 32'(got), 32'd0);
    chk("late_ack rdata",    rdata,    32'h0);
    chk("late_ack err",      32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
